fir_mac_sched: RTL and testbench

- Time-multiplexed FIR MAC scheduler. One signed multiplier-accumulator is shared between up to NUM_CH filter requesters: LPF-I, LPF-Q, Hilbert and delay branch.
- Once per audio frame (next_lrclk_fall), it walks each enabled channel's taps. It issues tap addresses to the requester's sample/coefficient storage, accumulates the products, then scales, saturates and publishes one output per channel.
- It sits between the downconverter output and the i2s_tx mode mux. It replaces per-tap parallel multipliers in the AM/SSB filters.

---
 rtl/fir_mac_sched.sv | 268 ++++++++++++++++++++++++++
 tb/tb_fir_mac_sched.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_sched.sv
// ============================================================================
// fir_mac_sched
// ----------------------------------------------------------------------------
// Time-multiplexed FIR multiply-accumulate scheduler. A single signed MAC is
// shared by up to NUM_CH filter requesters (LPF-I, LPF-Q, Hilbert, delay).
// On each frame strobe the enabled channels are visited in ascending order.
// For each channel the block streams tap addresses to the requester's
// sample/coefficient storage and accumulates the returned products. It then
// scales the sum by 2^-(CW-1), saturates it to DW bits and publishes it.
//
// Optional feature (macro FIR_MAC_ROUND_EN):
//   defined   : 2^(CW-2) is added before the scaling shift (round half up)
//   undefined : the scaling shift truncates toward -inf
//   Latency is the same in both builds.
//
// Ports:
//   mclk             clock
//   reset            synchronous active-high reset; aborts a running frame
//   next_lrclk_fall  frame-start strobe, one mclk wide
//   ch_en            per-channel enable, latched at frame start
//   ch_ntaps         per-channel tap count (ch0 in LSBs), latched at frame start
//   rd_en            tap read request
//   rd_ch            channel being read
//   rd_addr          tap index k
//   sample_in        x[n-k] for rd_ch, valid one cycle after rd_en
//   coef_in          b[k] for rd_ch (Q1.15), valid one cycle after rd_en
//   y_out            packed per-channel results, held between updates
//   y_valid          per-channel one-cycle pulse when y_out updates
//   frame_done       one-cycle pulse after the last enabled channel
//   busy             high from frame accept through frame_done
//   overrun          sticky; a strobe arrived while busy
// ============================================================================
module fir_mac_sched #(
  parameter int NUM_CH = 4,
  parameter int TAPS   = 51,
  parameter int DW     = 24,
  parameter int CW     = 16,
  parameter int AW     = 6,
  parameter int CHW    = 2
) (
  input  logic                 mclk,
  input  logic                 reset,
  input  logic                 next_lrclk_fall,
  input  logic [NUM_CH-1:0]    ch_en,
  input  logic [NUM_CH*AW-1:0] ch_ntaps,
  output logic                 rd_en,
  output logic [CHW-1:0]       rd_ch,
  output logic [AW-1:0]        rd_addr,
  input  logic [DW-1:0]        sample_in,
  input  logic [CW-1:0]        coef_in,
  output logic [NUM_CH*DW-1:0] y_out,
  output logic [NUM_CH-1:0]    y_valid,
  output logic                 frame_done,
  output logic                 busy,
  output logic                 overrun
);

  // Product and accumulator widths. The accumulator carries AW guard bits,
  // so TAPS full-scale products cannot overflow it.
  localparam int PW  = DW + CW;
  localparam int ACW = DW + CW + AW;

  localparam logic [AW-1:0] TAPS_MAX = AW'(TAPS);

  localparam logic signed [ACW-1:0] SAT_MAX = {{(ACW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACW-1:0] SAT_MIN = {{(ACW-DW+1){1'b1}}, {(DW-1){1'b0}}};

`ifdef FIR_MAC_ROUND_EN
  localparam logic signed [ACW-1:0] RND_BIAS = ACW'(1) << (CW-2);
`else
  localparam logic signed [ACW-1:0] RND_BIAS = '0;
`endif

  typedef enum logic [2:0] {
    IDLE,
    SEL,
    ISSUE,
    DRAIN,
    WRITE,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  // Latched frame configuration. en_pend loses a bit as each channel is
  // written, so SEL only has to find the lowest remaining bit.
  logic [NUM_CH-1:0]    en_pend;
  logic [NUM_CH*AW-1:0] ntaps_q;

  logic [CHW-1:0]       ch_q;
  logic [AW-1:0]        k_q;
  logic [AW-1:0]        last_k_q;
  logic                 rd_en_d;

  logic signed [ACW-1:0] acc_q;

  logic                 sel_found;
  logic [CHW-1:0]       sel_ch;
  logic [AW-1:0]        tap_req;
  logic [AW-1:0]        n_sel;

  logic signed [PW-1:0]  sample_x;
  logic signed [PW-1:0]  coef_x;
  logic signed [PW-1:0]  prod;
  logic signed [ACW-1:0] rounded;
  logic signed [ACW-1:0] shifted;
  logic [DW-1:0]         y_word;

  // Lowest-numbered channel still pending in this frame.
  always_comb begin
    sel_found = 1'b0;
    sel_ch    = '0;
    for (int i = NUM_CH-1; i >= 0; i--) begin
      if (en_pend[i]) begin
        sel_found = 1'b1;
        sel_ch    = CHW'(i);
      end
    end
  end

  // Requested tap count for the selected channel, clamped to TAPS.
  always_comb begin
    tap_req = ntaps_q[int'(sel_ch)*AW +: AW];
    n_sel   = (tap_req > TAPS_MAX) ? TAPS_MAX : tap_req;
  end

  // Full-precision signed product of the data returned for the previous
  // tap request.
  assign sample_x = PW'($signed(sample_in));
  assign coef_x   = PW'($signed(coef_in));
  assign prod     = sample_x * coef_x;

  // Q1.15 rescale (arithmetic shift), optional rounding bias, and clamp
  // to the signed DW-bit output range.
  always_comb begin
    rounded = acc_q + RND_BIAS;
    shifted = rounded >>> (CW-1);
    if (shifted > SAT_MAX) begin
      y_word = SAT_MAX[DW-1:0];
    end else if (shifted < SAT_MIN) begin
      y_word = SAT_MIN[DW-1:0];
    end else begin
      y_word = shifted[DW-1:0];
    end
  end

  // State register.
  always_ff @(posedge mclk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and the outputs that are pure functions of the state.
  // Read-side outputs are forced to zero outside ISSUE, so they are also
  // zero straight after reset.
  always_comb begin
    state_d    = state_q;
    rd_en      = 1'b0;
    rd_ch      = '0;
    rd_addr    = '0;
    busy       = 1'b1;
    frame_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (next_lrclk_fall) begin
          state_d = SEL;
        end
      end
      SEL: begin
        if (!sel_found) begin
          state_d = DONE;
        end else if (n_sel == '0) begin
          state_d = WRITE;
        end else begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        rd_en   = 1'b1;
        rd_ch   = ch_q;
        rd_addr = k_q;
        if (k_q == last_k_q) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = WRITE;
      end
      WRITE: begin
        state_d = SEL;
      end
      DONE: begin
        frame_done = 1'b1;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath. rd_en_d marks the cycle in which the storage is returning
  // data for the previous request; only then is the product accumulated.
  // The first ISSUE cycle therefore adds nothing, and DRAIN picks up the
  // last tap.
  always_ff @(posedge mclk) begin
    if (reset) begin
      en_pend  <= '0;
      ntaps_q  <= '0;
      ch_q     <= '0;
      k_q      <= '0;
      last_k_q <= '0;
      rd_en_d  <= 1'b0;
      acc_q    <= '0;
      y_out    <= '0;
      y_valid  <= '0;
      overrun  <= 1'b0;
    end else begin
      rd_en_d <= (state_q == ISSUE);
      y_valid <= '0;

      if (next_lrclk_fall && (state_q != IDLE)) begin
        overrun <= 1'b1;
      end

      unique case (state_q)
        IDLE: begin
          if (next_lrclk_fall) begin
            en_pend <= ch_en;
            ntaps_q <= ch_ntaps;
          end
        end
        SEL: begin
          if (sel_found) begin
            ch_q     <= sel_ch;
            k_q      <= '0;
            last_k_q <= n_sel - AW'(1);
            acc_q    <= '0;
          end
        end
        ISSUE: begin
          k_q <= k_q + AW'(1);
          if (rd_en_d) begin
            acc_q <= acc_q + ACW'(prod);
          end
        end
        DRAIN: begin
          if (rd_en_d) begin
            acc_q <= acc_q + ACW'(prod);
          end
        end
        WRITE: begin
          y_out[int'(ch_q)*DW +: DW] <= y_word;
          y_valid[ch_q]              <= 1'b1;
          en_pend[ch_q]              <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_sched.sv
// ============================================================================
// tb_fir_mac_sched
// ----------------------------------------------------------------------------
// Directed bench for fir_mac_sched. A table of frame vectors (enables, tap
// counts, constant or impulse data, expected per-channel results and busy
// length) is applied in a loop. Hand-written sequences then cover overrun,
// reset in the middle of a frame, and a clean frame after that reset.
// The requester storage is modelled behaviourally: it answers each read
// request with data one cycle later.
// ============================================================================
module tb_fir_mac_sched;

  localparam int NUM_CH = 4;
  localparam int TAPS   = 51;
  localparam int DW     = 24;
  localparam int CW     = 16;
  localparam int AW     = 6;
  localparam int CHW    = 2;

`ifdef FIR_MAC_ROUND_EN
  localparam logic [23:0] Y_HALF_LSB = 24'h000001;
  localparam logic [23:0] Y_MINUS_TINY = 24'h000000;
`else
  localparam logic [23:0] Y_HALF_LSB = 24'h000000;
  localparam logic [23:0] Y_MINUS_TINY = 24'hFFFFFF;
`endif

  logic                 mclk;
  logic                 reset;
  logic                 next_lrclk_fall;
  logic [NUM_CH-1:0]    ch_en;
  logic [NUM_CH*AW-1:0] ch_ntaps;
  logic                 rd_en;
  logic [CHW-1:0]       rd_ch;
  logic [AW-1:0]        rd_addr;
  logic [DW-1:0]        sample_in;
  logic [CW-1:0]        coef_in;
  logic [NUM_CH*DW-1:0] y_out;
  logic [NUM_CH-1:0]    y_valid;
  logic                 frame_done;
  logic                 busy;
  logic                 overrun;

  fir_mac_sched #(
    .NUM_CH(NUM_CH), .TAPS(TAPS), .DW(DW), .CW(CW), .AW(AW), .CHW(CHW)
  ) dut (
    .mclk            (mclk),
    .reset           (reset),
    .next_lrclk_fall (next_lrclk_fall),
    .ch_en           (ch_en),
    .ch_ntaps        (ch_ntaps),
    .rd_en           (rd_en),
    .rd_ch           (rd_ch),
    .rd_addr         (rd_addr),
    .sample_in       (sample_in),
    .coef_in         (coef_in),
    .y_out           (y_out),
    .y_valid         (y_valid),
    .frame_done      (frame_done),
    .busy            (busy),
    .overrun         (overrun)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  typedef struct {
    logic [3:0]  en;
    logic [23:0] ntaps;
    logic [23:0] samp;
    logic [15:0] coef;
    bit          imp;
    logic [95:0] y;
    int          busy_len;
  } vec_t;

  vec_t vecs[9];

  int check_cnt = 0;
  int pass_cnt  = 0;

  // Statistics gathered by the negedge monitor since the last clear.
  int cyc = 0;
  int busy_cnt, busy_start, fd_cnt, fd_cyc;
  int valid_cnt[4];
  int valid_cyc[4];
  int rd_cnt[4];

  // Requester storage model: constant data, or an impulse at tap 0.
  logic [23:0] cur_samp;
  logic [15:0] cur_coef;
  bit          cur_imp;
  logic        pend_en;
  logic [AW-1:0] pend_addr;

  logic [23:0] exp_hold[4];

  initial begin
    pend_en   = 1'b0;
    pend_addr = '0;
    sample_in = '0;
    coef_in   = '0;
    cur_samp  = '0;
    cur_coef  = '0;
    cur_imp   = 1'b0;
  end

  // Monitor and requester model, both evaluated mid-cycle.
  always @(negedge mclk) begin
    cyc++;
    if (busy) begin
      busy_cnt++;
      if (busy_start < 0) busy_start = cyc;
    end
    for (int c = 0; c < 4; c++) begin
      if (y_valid[c]) begin
        valid_cnt[c]++;
        if (valid_cyc[c] < 0) valid_cyc[c] = cyc;
      end
    end
    if (frame_done) begin
      fd_cnt++;
      if (fd_cyc < 0) fd_cyc = cyc;
    end
    if (rd_en) rd_cnt[rd_ch]++;
    if (pend_en && !(cur_imp && pend_addr != '0)) begin
      sample_in = cur_samp;
      coef_in   = cur_coef;
    end else begin
      sample_in = '0;
      coef_in   = '0;
    end
    pend_en   = rd_en;
    pend_addr = rd_addr;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    check_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clearStats();
    busy_cnt   = 0;
    busy_start = -1;
    fd_cnt     = 0;
    fd_cyc     = -1;
    for (int c = 0; c < 4; c++) begin
      valid_cnt[c] = 0;
      valid_cyc[c] = -1;
      rd_cnt[c]    = 0;
    end
  endtask

  // Pulse the strobe, then scramble the configuration inputs so that only
  // the latched copy can produce correct results.
  task automatic startFrame(input logic [3:0] en, input logic [23:0] nt);
    @(posedge mclk); #1;
    ch_en           = en;
    ch_ntaps        = nt;
    next_lrclk_fall = 1'b1;
    @(posedge mclk); #1;
    next_lrclk_fall = 1'b0;
    ch_en           = ~en;
    ch_ntaps        = ~nt;
  endtask

  task automatic applyStimulus(input logic [3:0] en, input logic [23:0] nt,
                               input logic [23:0] s, input logic [15:0] c,
                               input bit imp, input int ovr_at);
    bit done;
    clearStats();
    cur_samp = s;
    cur_coef = c;
    cur_imp  = imp;
    startFrame(en, nt);
    done = 1'b0;
    for (int i = 1; i < 2000 && !done; i++) begin
      next_lrclk_fall = (i == ovr_at);
      @(posedge mclk); #1;
      if (fd_cnt != 0) done = 1'b1;
    end
    next_lrclk_fall = 1'b0;
    repeat (3) @(posedge mclk);
    #1;
    checkOutput("frame_timeout", 64'(!done), 64'd0);
  endtask

  function automatic int expReads(input logic [3:0] en, input logic [23:0] nt, input int c);
    int n;
    n = int'(nt[c*6 +: 6]);
    if (n > TAPS) n = TAPS;
    return en[c] ? n : 0;
  endfunction

  initial begin
    bit found;

    vecs[0] = '{4'b0001, {6'd0, 6'd0, 6'd0, 6'd51}, 24'h000100, 16'h0FA4, 1'b1,
                {24'h0, 24'h0, 24'h0, 24'h00001F}, 56};
    vecs[1] = '{4'b0010, {6'd0, 6'd0, 6'd51, 6'd0}, 24'h7FFFFF, 16'h7FFF, 1'b0,
                {24'h0, 24'h0, 24'h7FFFFF, 24'h0}, 56};
    vecs[2] = '{4'b0010, {6'd0, 6'd0, 6'd51, 6'd0}, 24'h800000, 16'h7FFF, 1'b0,
                {24'h0, 24'h0, 24'h800000, 24'h0}, 56};
    vecs[3] = '{4'b1010, {6'd51, 6'd0, 6'd0, 6'd41}, 24'h000100, 16'h0100, 1'b0,
                {24'h000066, 24'h0, 24'h000000, 24'h0}, 58};
    vecs[4] = '{4'b0001, {6'd0, 6'd0, 6'd0, 6'd1}, 24'h000001, 16'h4000, 1'b0,
                {24'h0, 24'h0, 24'h0, Y_HALF_LSB}, 6};
    vecs[5] = '{4'b0100, {6'd0, 6'd63, 6'd0, 6'd0}, 24'h000100, 16'h0100, 1'b0,
                {24'h0, 24'h000066, 24'h0, 24'h0}, 56};
    vecs[6] = '{4'b0001, {6'd0, 6'd0, 6'd0, 6'd3}, 24'hFFFE00, 16'h4000, 1'b0,
                {24'h0, 24'h0, 24'h0, 24'hFFFD00}, 8};
    vecs[7] = '{4'b0001, {6'd0, 6'd0, 6'd0, 6'd1}, 24'hFFFFFF, 16'h0001, 1'b0,
                {24'h0, 24'h0, 24'h0, Y_MINUS_TINY}, 6};
    vecs[8] = '{4'b0000, {6'd51, 6'd51, 6'd51, 6'd51}, 24'h000100, 16'h0100, 1'b0,
                {24'h0, 24'h0, 24'h0, 24'h0}, 2};

    for (int c = 0; c < 4; c++) exp_hold[c] = '0;
    clearStats();

    reset           = 1'b1;
    next_lrclk_fall = 1'b0;
    ch_en           = '0;
    ch_ntaps        = '0;
    repeat (3) @(posedge mclk);
    #1;
    reset = 1'b0;

    checkOutput("rst_y_out", 64'(y_out[63:0] | 64'(y_out[95:64])), 64'd0);
    checkOutput("rst_y_valid", 64'(y_valid), 64'd0);
    checkOutput("rst_frame_done", 64'(frame_done), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_overrun", 64'(overrun), 64'd0);
    checkOutput("rst_rd", 64'({rd_en, rd_ch, rd_addr}), 64'd0);

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].en, vecs[i].ntaps, vecs[i].samp, vecs[i].coef, vecs[i].imp, 0);
      for (int c = 0; c < 4; c++) begin
        if (vecs[i].en[c]) exp_hold[c] = vecs[i].y[c*24 +: 24];
        checkOutput($sformatf("v%0d_y%0d", i, c), 64'(y_out[c*DW +: DW]), 64'(exp_hold[c]));
        checkOutput($sformatf("v%0d_valid%0d", i, c), 64'(valid_cnt[c]), 64'(vecs[i].en[c]));
        checkOutput($sformatf("v%0d_reads%0d", i, c), 64'(rd_cnt[c]),
                    64'(expReads(vecs[i].en, vecs[i].ntaps, c)));
      end
      checkOutput($sformatf("v%0d_frame_done", i), 64'(fd_cnt), 64'd1);
      checkOutput($sformatf("v%0d_busy_len", i), 64'(busy_cnt), 64'(vecs[i].busy_len));
      if (i == 0) begin
        checkOutput("impulse_valid_latency", 64'(valid_cyc[0] - busy_start), 64'd54);
        checkOutput("impulse_done_after_valid", 64'(fd_cyc - valid_cyc[0]), 64'd1);
      end
    end

    // Overrun: second strobe 100 cycles into a full 4x51 frame.
    checkOutput("ovr_clear_before", 64'(overrun), 64'd0);
    applyStimulus(4'b1111, {4{6'd51}}, 24'h000100, 16'h0100, 1'b0, 100);
    for (int c = 0; c < 4; c++) begin
      exp_hold[c] = 24'h000066;
      checkOutput($sformatf("ovr_y%0d", c), 64'(y_out[c*DW +: DW]), 64'h66);
      checkOutput($sformatf("ovr_valid%0d", c), 64'(valid_cnt[c]), 64'd1);
    end
    checkOutput("ovr_frame_done", 64'(fd_cnt), 64'd1);
    checkOutput("ovr_busy_len", 64'(busy_cnt), 64'd218);
    checkOutput("ovr_flag", 64'(overrun), 64'd1);
    repeat (20) @(posedge mclk);
    #1;
    checkOutput("ovr_sticky", 64'(overrun), 64'd1);

    // Reset in the middle of channel 2's tap stream.
    clearStats();
    cur_samp = 24'h000200;
    cur_coef = 16'h0100;
    cur_imp  = 1'b0;
    startFrame(4'b1111, {4{6'd51}});
    found = 1'b0;
    for (int i = 0; i < 600 && !found; i++) begin
      @(posedge mclk); #1;
      if (rd_en && rd_ch == 2'd2 && rd_addr == 6'd29) found = 1'b1;
    end
    checkOutput("midrst_reached", 64'(found), 64'd1);
    checkOutput("midrst_ch1_written", 64'(y_out[1*DW +: DW]), 64'h0000CC);
    reset = 1'b1;
    @(posedge mclk); #1;
    reset = 1'b0;
    checkOutput("midrst_rd_en", 64'(rd_en), 64'd0);
    checkOutput("midrst_busy", 64'(busy), 64'd0);
    checkOutput("midrst_overrun", 64'(overrun), 64'd0);
    for (int c = 0; c < 4; c++) begin
      exp_hold[c] = '0;
      checkOutput($sformatf("midrst_y%0d", c), 64'(y_out[c*DW +: DW]), 64'd0);
    end
    clearStats();
    repeat (300) @(posedge mclk);
    #1;
    checkOutput("midrst_no_valid", 64'(valid_cnt[0] + valid_cnt[1] + valid_cnt[2] + valid_cnt[3]), 64'd0);
    checkOutput("midrst_no_done", 64'(fd_cnt), 64'd0);
    checkOutput("midrst_no_busy", 64'(busy_cnt), 64'd0);

    // Clean frame after the aborted one.
    applyStimulus(4'b0001, {6'd0, 6'd0, 6'd0, 6'd51}, 24'h000100, 16'h0FA4, 1'b1, 0);
    checkOutput("clean_y0", 64'(y_out[0 +: DW]), 64'h1F);
    checkOutput("clean_y_rest", 64'(y_out[NUM_CH*DW-1:DW]), 64'd0);
    checkOutput("clean_valid0", 64'(valid_cnt[0]), 64'd1);
    checkOutput("clean_frame_done", 64'(fd_cnt), 64'd1);
    checkOutput("clean_busy_len", 64'(busy_cnt), 64'd56);
    checkOutput("clean_overrun", 64'(overrun), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
